// File: rtl/zero_detect_persist.sv
// Multi-channel zero/nonzero detector with debounced set/release and sticky history.
// det follows the qualifying in_valid edge; any_det/all_det lag det by one cycle. No backpressure.
module zero_detect_persist #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      mode,
  input  logic [CNT_W-1:0]          set_cnt,
  input  logic [CNT_W-1:0]          rel_cnt,
  input  logic                      clr_sticky,
  output logic [CHANNELS-1:0]       det,
  output logic [CHANNELS-1:0]       det_rise,
  output logic [CHANNELS-1:0]       sticky,
  output logic                      any_det,
  output logic                      all_det
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q   [CHANNELS];
  logic [CNT_W-1:0]    cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] sticky_q, sticky_d;
  logic [CHANNELS-1:0] det_now;
  logic                mode_q;
  logic                any_q, all_q;
  logic [CNT_W:0]      set_eff, rel_eff;
  logic [CNT_W:0]      cnt_inc;
  logic [CNT_W-1:0]    cnt_sat;

  always_comb begin
    // Zero thresholds behave as one; the extra bit keeps cnt+1 from wrapping in the compare.
    set_eff  = (set_cnt == '0) ? (CNT_W+1)'(1) : {1'b0, set_cnt};
    rel_eff  = (rel_cnt == '0) ? (CNT_W+1)'(1) : {1'b0, rel_cnt};
    hit      = '0;
    rise_d   = '0;
    det_now  = '0;
    cnt_inc  = '0;
    cnt_sat  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      det_now[k] = (state_q[k] == ACTIVE);
      hit[k]     = (in_data[k*WIDTH +: WIDTH] == '0) ^ mode;
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      cnt_inc    = {1'b0, cnt_q[k]} + (CNT_W+1)'(1);
      cnt_sat    = (&cnt_q[k]) ? cnt_q[k] : cnt_inc[CNT_W-1:0];
      if (mode != mode_q) begin
        // Mode switch flushes every channel and drops the beat on this edge.
        state_d[k] = IDLE;
        cnt_d[k]   = '0;
      end else if (in_valid) begin
        if (state_q[k] == IDLE) begin
          if (!hit[k]) begin
            cnt_d[k] = '0;
          end else if (cnt_inc >= set_eff) begin
            state_d[k] = ACTIVE;
            cnt_d[k]   = '0;
            rise_d[k]  = 1'b1;
          end else begin
            cnt_d[k] = cnt_sat;
          end
        end else begin
          if (hit[k]) begin
            cnt_d[k] = '0;
          end else if (cnt_inc >= rel_eff) begin
            state_d[k] = IDLE;
            cnt_d[k]   = '0;
          end else begin
            cnt_d[k] = cnt_sat;
          end
        end
      end
    end
    // A new rise beats a coincident clear.
    sticky_d = (sticky_q & ~{CHANNELS{clr_sticky}}) | rise_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= IDLE;
        cnt_q[k]   <= '0;
      end
      rise_q   <= '0;
      sticky_q <= '0;
      mode_q   <= 1'b0;
      any_q    <= 1'b0;
      all_q    <= 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      rise_q   <= rise_d;
      sticky_q <= sticky_d;
      mode_q   <= mode;
      any_q    <= |det_now;
      all_q    <= &det_now;
    end
  end

  assign det      = det_now;
  assign det_rise = rise_q;
  assign sticky   = sticky_q;
  assign any_det  = any_q;
  assign all_det  = all_q;

endmodule

// File: tb/tb_zero_detect_persist.sv
// Directed scenarios plus randomized traffic checked against a run-length reference model.
module tb_zero_detect_persist;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        mode = 1'b0;
  logic [7:0]  set_cnt = 8'd3;
  logic [7:0]  rel_cnt = 8'd2;
  logic        clr_sticky = 1'b0;
  logic [3:0]  det, det_rise, sticky;
  logic        any_det, all_det;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: run lengths per channel as plain integers.
  int         m_run [4];
  logic [3:0] m_det, m_rise, m_sticky;
  logic       m_any, m_all, m_mode_q;

  zero_detect_persist #(.WIDTH(8), .CHANNELS(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .mode(mode),
    .set_cnt(set_cnt), .rel_cnt(rel_cnt), .clr_sticky(clr_sticky),
    .det(det), .det_rise(det_rise), .sticky(sticky), .any_det(any_det), .all_det(all_det)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input logic [7:0] c0, input logic [7:0] c1,
                                     input logic [7:0] c2, input logic [7:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_run[k] = 0;
    m_det = '0; m_rise = '0; m_sticky = '0; m_any = 1'b0; m_all = 1'b0; m_mode_q = 1'b0;
  endtask

  task automatic model_edge();
    logic [3:0] prev;
    int se, re;
    logic h;
    prev   = m_det;
    m_rise = '0;
    se = (set_cnt == 0) ? 1 : int'(set_cnt);
    re = (rel_cnt == 0) ? 1 : int'(rel_cnt);
    if (mode != m_mode_q) begin
      m_det = '0;
      for (int k = 0; k < 4; k++) m_run[k] = 0;
    end else if (in_valid) begin
      for (int k = 0; k < 4; k++) begin
        h = (((in_data >> (8*k)) & 32'hFF) == 0) ^ mode;
        if (h != m_det[k]) begin
          m_run[k] = m_run[k] + 1;
          if (m_run[k] >= (m_det[k] ? re : se)) begin
            m_rise[k] = ~m_det[k];
            m_det[k]  = ~m_det[k];
            m_run[k]  = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end
    end
    m_sticky = (clr_sticky ? 4'b0 : m_sticky) | m_rise;
    m_any    = |prev;
    m_all    = &prev;
    m_mode_q = mode;
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic c);
    in_valid = v; in_data = d; clr_sticky = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({det, det_rise, sticky, any_det, all_det} !== 14'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b exp 0", {det, det_rise, sticky, any_det, all_det});
    end
    #2 rst = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    mode = 1'b0; set_cnt = 8'd3; rel_cnt = 8'd2;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, pk(8'h00, 8'h55, 8'h55, 8'h55), 1'b0);
      n_cmp++;
      if (det !== 4'b0000) begin n_fail++; $display("FAIL basic_early beat %0d got %b exp 0000", i, det); end
    end
    step(1'b1, pk(8'h00, 8'h55, 8'h55, 8'h55), 1'b0);
    n_cmp++;
    if ({det, det_rise, sticky} !== 12'b0001_0001_0001) begin
      n_fail++; $display("FAIL basic_assert got det/rise/sticky %b exp 000100010001", {det, det_rise, sticky});
    end
    n_cmp++;
    if (any_det !== 1'b0) begin n_fail++; $display("FAIL basic_any_lag got %b exp 0", any_det); end
    step(1'b1, pk(8'h00, 8'h55, 8'h55, 8'h55), 1'b0);
    n_cmp++;
    if ({det, det_rise, any_det, all_det} !== 10'b0001_0000_10) begin
      n_fail++; $display("FAIL basic_hold got %b exp 0001000010", {det, det_rise, any_det, all_det});
    end
  endtask

  task automatic test_hysteresis();
    logic [7:0] s [4] = '{8'h10, 8'h00, 8'h10, 8'h10};
    logic       e [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pk(s[i], 8'h55, 8'h55, 8'h55), 1'b0);
      n_cmp++;
      if (det[0] !== e[i] || det_rise !== 4'b0) begin
        n_fail++; $display("FAIL hyst beat %0d got det0 %b rise %b exp det0 %b rise 0000", i, det[0], det_rise, e[i]);
      end
    end
  endtask

  task automatic test_persistence();
    logic [7:0] s [6] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    logic [3:0] e [6] = '{4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0001};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, pk(s[i], 8'h55, 8'h55, 8'h55), 1'b0);
      n_cmp++;
      if (det !== e[i]) begin n_fail++; $display("FAIL persist beat %0d got %b exp %b", i, det, e[i]); end
    end
  endtask

  task automatic test_gaps();
    repeat (2) step(1'b1, pk(8'h55, 8'h55, 8'h55, 8'h55), 1'b0);
    set_cnt = 8'd2;
    step(1'b1, pk(8'h00, 8'h55, 8'h55, 8'h55), 1'b0);
    repeat (5) step(1'b0, 32'hFFFF_FFFF, 1'b0);
    n_cmp++;
    if (det !== 4'b0000) begin n_fail++; $display("FAIL gap_hold got %b exp 0000", det); end
    step(1'b1, pk(8'h00, 8'h55, 8'h55, 8'h55), 1'b0);
    n_cmp++;
    if (det !== 4'b0001 || det_rise !== 4'b0001) begin
      n_fail++; $display("FAIL gap_assert got det %b rise %b exp 0001 0001", det, det_rise);
    end
  endtask

  task automatic test_nonzero_mode();
    set_cnt = 8'd0; mode = 1'b1;
    step(1'b1, pk(8'h11, 8'h22, 8'h33, 8'h44), 1'b1);
    n_cmp++;
    if ({det, det_rise, sticky} !== 12'b0) begin
      n_fail++; $display("FAIL mode_flush got %b exp 0", {det, det_rise, sticky});
    end
    step(1'b1, pk(8'h11, 8'h22, 8'h33, 8'h44), 1'b0);
    n_cmp++;
    if ({det, det_rise, sticky} !== 12'hFFF) begin
      n_fail++; $display("FAIL nz_assert got %b exp 111111111111", {det, det_rise, sticky});
    end
    step(1'b0, 32'h0, 1'b0);
    n_cmp++;
    if ({any_det, all_det, det_rise} !== 6'b11_0000) begin
      n_fail++; $display("FAIL nz_any_all got %b exp 110000", {any_det, all_det, det_rise});
    end
    mode = 1'b0;
    step(1'b1, 32'h0, 1'b0);
    n_cmp++;
    if ({det, det_rise, sticky} !== 12'b0000_0000_1111) begin
      n_fail++; $display("FAIL mode_toggle got %b exp 000000001111", {det, det_rise, sticky});
    end
    step(1'b1, pk(8'h01, 8'h02, 8'h00, 8'h04), 1'b1);
    n_cmp++;
    if ({det, sticky} !== 8'b0100_0100) begin
      n_fail++; $display("FAIL clr_vs_rise got det/sticky %b exp 01000100", {det, sticky});
    end
  endtask

  task automatic test_reset_midcount();
    set_cnt = 8'd3; rel_cnt = 8'd2; mode = 1'b0;
    repeat (2) step(1'b1, pk(8'h55, 8'h55, 8'h55, 8'h55), 1'b0);
    repeat (2) step(1'b1, pk(8'h00, 8'h55, 8'h55, 8'h55), 1'b0);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({det, det_rise, sticky, any_det, all_det} !== 14'b0) begin
      n_fail++; $display("FAIL async_reset got %b exp 0", {det, det_rise, sticky, any_det, all_det});
    end
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, pk(8'h00, 8'h55, 8'h55, 8'h55), 1'b0);
      n_cmp++;
      if (det !== ((i == 2) ? 4'b0001 : 4'b0000)) begin
        n_fail++; $display("FAIL post_reset beat %0d got %b exp %b", i, det, (i == 2) ? 4'b0001 : 4'b0000);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 9) == 0) set_cnt = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) rel_cnt = 8'($urandom_range(0, 4));
      for (int k = 0; k < 4; k++)
        d[8*k +: 8] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      step(($urandom_range(0, 9) < 7), d, ($urandom_range(0, 9) == 0));
      n_cmp++;
      if (det !== m_det) begin n_fail++; $display("FAIL rnd_det cyc %0d got %b exp %b", cyc, det, m_det); end
      n_cmp++;
      if (det_rise !== m_rise) begin n_fail++; $display("FAIL rnd_rise cyc %0d got %b exp %b", cyc, det_rise, m_rise); end
      n_cmp++;
      if (sticky !== m_sticky) begin n_fail++; $display("FAIL rnd_sticky cyc %0d got %b exp %b", cyc, sticky, m_sticky); end
      n_cmp++;
      if (any_det !== m_any) begin n_fail++; $display("FAIL rnd_any cyc %0d got %b exp %b", cyc, any_det, m_any); end
      n_cmp++;
      if (all_det !== m_all) begin n_fail++; $display("FAIL rnd_all cyc %0d got %b exp %b", cyc, all_det, m_all); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hysteresis();
    test_persistence();
    test_gaps();
    test_nonzero_mode();
    test_reset_midcount();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
